// File: rtl/instruction_fetch.sv
// instruction_fetch: PC and imem req/ack fetch feeding an IF/ID register, with a stall hold buffer and redirect drain.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [31:0] fetch_count
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;
  state_t state;
  logic [31:0] pc, pend, hold_instr, hold_pc, tgt;
  assign tgt = redirect_pc & ~32'd3;
  assign imem_req = state == FETCH || state == DRAIN;
  assign imem_addr = pc;
  assign if_pc_plus4 = if_pc + 32'd4;
  assign opcode = if_instr[31:26];
  assign funct = if_instr[5:0];
  assign rs = if_instr[25:21];
  assign rt = if_instr[20:16];
  assign rd = if_instr[15:11];
  assign imm16 = if_instr[15:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      pend <= '0;
      hold_instr <= '0;
      hold_pc <= '0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc <= '0;
      fetch_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          if (redirect) pc <= tgt;
        end
        FETCH: begin
          if (redirect) begin
            if_valid <= 1'b0;
            if (imem_ack) pc <= tgt;
            else begin
              // the address stays put until the outstanding request is acked
              pend <= tgt;
              state <= DRAIN;
            end
          end else if (imem_ack) begin
            pc <= pc + 32'd4;
            if (stall) begin
              hold_instr <= imem_rdata;
              hold_pc <= pc;
              state <= HOLD;
            end else begin
              if_instr <= imem_rdata;
              if_pc <= pc;
              if_valid <= 1'b1;
              fetch_count <= fetch_count + 32'd1;
            end
          end else if (!stall) if_valid <= 1'b0;
        end
        DRAIN: begin
          if (redirect) pend <= tgt;
          if (imem_ack) begin
            pc <= redirect ? tgt : pend;
            state <= FETCH;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc <= tgt;
            if_valid <= 1'b0;
            state <= FETCH;
          end else if (!stall) begin
            if_instr <= hold_instr;
            if_pc <= hold_pc;
            if_valid <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized fetch stream checked against a program-order PC model via a load scoreboard.
module tb_instruction_fetch;
  localparam logic [31:0] RPC = 32'h0000_0100;
  logic clk = 1'b0, rst_n = 1'b0, imem_ack = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rdata, imem_addr, if_instr, if_pc, if_pc_plus4, fetch_count;
  logic imem_req, if_valid;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic [15:0] imm16;
  int n_err = 0, n_chk = 0, lat = 0, wc = 0;
  logic p_req = 1'b0, p_ack = 1'b0;
  logic [31:0] q[$];

  instruction_fetch #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
    .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
    .imm16(imm16), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h500) return 32'h8C43_0004;
    if (a == 32'h504) return 32'h0043_2020;
    if (a < 32'h1000) return a;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_reset();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, RPC);
    check("rst_valid", {31'b0, if_valid}, 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_pc", if_pc, 32'd0);
    check("rst_pc4", if_pc_plus4, 32'd4);
    check("rst_fields", {opcode, funct, rs, rt, rd, 5'b0}, 32'd0);
    check("rst_imm", {16'b0, imm16}, 32'd0);
    check("rst_count", fetch_count, 32'd0);
  endtask

  // waits for the first cycle of a fresh, not-yet-acked request
  task automatic wait_first();
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1);
      found = imem_req && !imem_ack && wc == 0;
    end
    n_chk++;
    if (!found) begin
      n_err++;
      $display("FAIL wait_first: no fresh request within 20 cycles");
    end
  endtask

  // memory: ack after `lat` cycles of a request (0 = same cycle, negative = random)
  initial forever begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      wc = 0;
      imem_ack = 1'b0;
    end else begin
      wc = (p_req && !p_ack) ? wc + 1 : 0;
      imem_ack = imem_req && (lat == 0 || (lat < 0 ? $urandom_range(0, 9) < 6 : wc >= lat - 1));
    end
    p_req = imem_req;
    p_ack = imem_ack;
  end

  // program-order model: next PC to reach IF/ID is the reset PC or the latest redirect target, then +4 each load
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n || redirect) begin
      q.delete();
      q.push_back(!rst_n ? RPC : redirect_pc & ~32'd3);
    end
  end

  initial begin
    logic [31:0] prev, e, w, s_addr;
    int loads;
    logic s_hold;
    prev = '0;
    loads = 0;
    s_hold = 1'b0;
    s_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = '0;
        loads = 0;
        s_hold = 1'b0;
      end else begin
        if (s_hold && imem_req) check("addr_stable", imem_addr, s_addr);
        if (fetch_count != prev) begin
          if (q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL load_unexpected: fetch_count %0d with empty model", fetch_count);
          end else begin
            e = q.pop_front();
            q.push_back(e + 32'd4);
            loads++;
            w = mem_word(e);
            check("load_pc", if_pc, e);
            check("load_instr", if_instr, w);
            check("load_valid", {31'b0, if_valid}, 32'd1);
            check("load_pc4", if_pc_plus4, e + 32'd4);
            check("load_fields", {opcode, funct, rs, rt, rd, 5'b0}, {w[31:26], w[5:0], w[25:11], 5'b0});
            check("load_imm", {16'b0, imm16}, {16'b0, w[15:0]});
            check("load_count", fetch_count, loads);
          end
        end
        prev = fetch_count;
        s_hold = imem_req && !imem_ack;
        s_addr = imem_addr;
      end
    end
  end

  initial begin
    logic [31:0] ri, rp, sa;
    cyc(2);
    chk_reset();
    rst_n = 1'b1;
    check("first_req_idle", {31'b0, imem_req}, 32'd0);
    cyc(1);
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("seq_addr0", imem_addr, 32'h100);
    cyc(1);
    check("seq_addr1", imem_addr, 32'h104);
    check("seq_ifpc0", if_pc, 32'h100);
    cyc(1);
    check("seq_addr2", imem_addr, 32'h108);
    check("seq_ifpc1", if_pc, 32'h104);
    cyc(1);
    check("seq_ifpc2", if_pc, 32'h108);
    check("seq_count", fetch_count, 32'd3);

    redirect = 1'b1;
    redirect_pc = 32'h502;
    cyc(1);
    redirect = 1'b0;
    cyc(1);
    check("lw_valid", {31'b0, if_valid}, 32'd1);
    check("lw_pc", if_pc, 32'h500);
    check("lw_opcode", {26'b0, opcode}, 32'h23);
    check("lw_rs_rt", {22'b0, rs, rt}, {22'b0, 5'd2, 5'd3});
    check("lw_imm", {16'b0, imm16}, 32'd4);
    cyc(1);
    check("add_opcode", {26'b0, opcode}, 32'h0);
    check("add_funct", {26'b0, funct}, 32'h20);
    check("add_rd", {27'b0, rd}, 32'd4);

    stall = 1'b1;
    ri = if_instr;
    rp = if_pc;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("stall_req", {31'b0, imem_req}, 32'd0);
      check("stall_instr", if_instr, ri);
      check("stall_pc", if_pc, rp);
      check("stall_valid", {31'b0, if_valid}, 32'd1);
    end
    stall = 1'b0;
    cyc(1);
    check("unstall_pc", if_pc, rp + 32'd4);

    lat = 2;
    wait_first();
    sa = imem_addr;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    cyc(1);
    redirect = 1'b0;
    check("drain_addr", imem_addr, sa);
    check("drain_req", {31'b0, imem_req}, 32'd1);
    check("drain_valid", {31'b0, if_valid}, 32'd0);
    cyc(1);
    check("drain_target", imem_addr, 32'h200);
    check("drain_valid2", {31'b0, if_valid}, 32'd0);

    lat = 3;
    wait_first();
    redirect = 1'b1;
    redirect_pc = 32'h300;
    cyc(1);
    redirect_pc = 32'h400;
    cyc(1);
    redirect = 1'b0;
    cyc(1);
    check("latest_target", imem_addr, 32'h400);
    check("latest_valid", {31'b0, if_valid}, 32'd0);

    lat = 0;
    cyc(3);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cyc(1);
    redirect = 1'b0;
    cyc(1);
    check("wrap_ifpc", if_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", if_pc_plus4, 32'd0);
    check("wrap_addr", imem_addr, 32'd0);

    lat = -1;
    for (int i = 0; i < 3000; i++) begin
      stall = $urandom_range(0, 9) < 3;
      redirect = $urandom_range(0, 99) < 8;
      rp = $urandom();
      if ($urandom_range(0, 1) == 1) rp &= 32'hFFF;
      redirect_pc = rp;
      cyc(1);
    end
    stall = 1'b0;
    redirect = 1'b0;
    cyc(4);

    lat = 3;
    wait_first();
    #1 rst_n = 1'b0;
    #1 chk_reset();
    cyc(2);
    rst_n = 1'b1;
    lat = 0;
    cyc(5);
    check("rerun_count", fetch_count, 32'd4);
    check("rerun_ifpc", if_pc, RPC + 32'hC);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
